// File: rtl/boid_mmio_bridge_pkg.sv
// Shared definitions for the boid MMIO bridge: FSM encoding, STATUS layout, window offsets.
package boid_mmio_bridge_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StPending = 2'd1,
      StCopy    = 2'd2
   } state_e;

   localparam int unsigned STAT_PENDING_BIT = 0;
   localparam int unsigned STAT_BANK_BIT    = 1;
   localparam int unsigned STAT_COPY_BIT    = 2;
   localparam int unsigned STAT_FC_LSB      = 8;
   localparam int unsigned FC_W             = 8;

   function automatic logic [8:0] commit_off(int unsigned n_boids);
      return 9'(2 * n_boids);
   endfunction

   function automatic logic [8:0] status_off(int unsigned n_boids);
      return 9'(2 * n_boids + 1);
   endfunction

endpackage

// File: rtl/boid_bank_ram.sv
// Two-bank boid coordinate store: CPU and copy write ports (CPU wins on the same word),
// display and copy-source read ports, and a CPU read-back port.
module boid_bank_ram
   import boid_mmio_bridge_pkg::*;
#(
   parameter int unsigned N_BOIDS = 64,
   parameter int unsigned COORD_W = 10,
   localparam int unsigned IDX_W  = $clog2(N_BOIDS)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_cpu_we,
   input  logic               i_cpu_bank,
   input  logic [IDX_W-1:0]   i_cpu_idx,
   input  logic               i_cpu_is_y,
   input  logic [COORD_W-1:0] i_cpu_data,
   input  logic               i_cp_we_x,
   input  logic               i_cp_we_y,
   input  logic               i_cp_bank,
   input  logic [IDX_W-1:0]   i_cp_idx,
   input  logic [COORD_W-1:0] i_cp_x,
   input  logic [COORD_W-1:0] i_cp_y,
   input  logic               i_disp_bank,
   input  logic [IDX_W-1:0]   i_disp_idx,
   output logic [COORD_W-1:0] o_disp_x,
   output logic [COORD_W-1:0] o_disp_y,
   input  logic               i_src_bank,
   input  logic [IDX_W-1:0]   i_src_idx,
   output logic [COORD_W-1:0] o_src_x,
   output logic [COORD_W-1:0] o_src_y,
   input  logic               i_rb_bank,
   input  logic [IDX_W-1:0]   i_rb_idx,
   input  logic               i_rb_is_y,
   output logic [COORD_W-1:0] o_rb_data
);

   logic [COORD_W-1:0] r_x [2][N_BOIDS];
   logic [COORD_W-1:0] r_y [2][N_BOIDS];

   // CPU writes are issued after copy writes so the CPU value lands on a shared word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N_BOIDS; i++) begin
               r_x[b][i] <= '0;
               r_y[b][i] <= '0;
            end
         end
      end else begin
         if (i_cp_we_x) r_x[i_cp_bank][i_cp_idx] <= i_cp_x;
         if (i_cp_we_y) r_y[i_cp_bank][i_cp_idx] <= i_cp_y;
         if (i_cpu_we && !i_cpu_is_y) r_x[i_cpu_bank][i_cpu_idx] <= i_cpu_data;
         if (i_cpu_we && i_cpu_is_y)  r_y[i_cpu_bank][i_cpu_idx] <= i_cpu_data;
      end
   end

   assign o_disp_x  = r_x[i_disp_bank][i_disp_idx];
   assign o_disp_y  = r_y[i_disp_bank][i_disp_idx];
   assign o_src_x   = r_x[i_src_bank][i_src_idx];
   assign o_src_y   = r_y[i_src_bank][i_src_idx];
   assign o_rb_data = i_rb_is_y ? r_y[i_rb_bank][i_rb_idx] : r_x[i_rb_bank][i_rb_idx];

endmodule

// File: rtl/boid_mmio_bridge.sv
// Intercepts CPU stores to the boid window, maintains a double-buffered position table and
// swaps banks at frame boundaries, copying the displayed bank back into the write bank.
module boid_mmio_bridge
   import boid_mmio_bridge_pkg::*;
#(
   parameter int unsigned N_BOIDS   = 64,
   parameter int unsigned COORD_W   = 10,
   parameter logic [11:0] BASE_ADDR = 12'hC00,
   localparam int unsigned IDX_W    = $clog2(N_BOIDS)
) (
   input  logic               clock,
   input  logic               CPU_RESETN,
   input  logic               cpu_wren,
   input  logic [11:0]        cpu_addr,
   input  logic [31:0]        cpu_data,
   output logic [31:0]        cpu_q,
   output logic               ram_wren,
   input  logic [31:0]        ram_q,
   input  logic               vga_frame_start,
   input  logic [IDX_W-1:0]   vga_rd_idx,
   output logic [COORD_W-1:0] vga_rd_x,
   output logic [COORD_W-1:0] vga_rd_y,
   output logic               active_bank,
   output logic               busy
);

   localparam logic [8:0] OFF_COMMIT = commit_off(N_BOIDS);
   localparam logic [8:0] OFF_STATUS = status_off(N_BOIDS);

   state_e             r_state, w_state_d;
   logic               r_active_bank, w_active_bank_d;
   logic               r_commit_latched, w_commit_latched_d;
   logic [IDX_W-1:0]   r_copy_idx, w_copy_idx_d;
   logic               w_swap;
   logic [N_BOIDS-1:0] r_dirty_x, r_dirty_y, w_set_x, w_set_y;
   logic [FC_W-1:0]    r_frame_count;
   logic               r_sel_ram;
   logic [31:0]        r_mmio_q, w_mmio_d, w_status;
   logic [COORD_W-1:0] r_rd_x, r_rd_y;

   logic               w_in_win, w_is_coord, w_is_commit, w_is_status;
   logic [8:0]         w_off;
   logic [IDX_W-1:0]   w_cpu_idx;
   logic               w_cpu_is_y, w_coord_we, w_commit_st, w_copying;
   logic               w_cp_we_x, w_cp_we_y;
   logic [COORD_W-1:0] w_rb_data, w_disp_x, w_disp_y, w_src_x, w_src_y;
   logic               w_unused;

   // BASE_ADDR is 256-aligned, so the window is a match on the top nibble.
   assign w_in_win    = cpu_addr[11:8] == BASE_ADDR[11:8];
   assign w_off       = {1'b0, cpu_addr[7:0]};
   assign w_is_coord  = w_in_win && (w_off < OFF_COMMIT);
   assign w_is_commit = w_in_win && (w_off == OFF_COMMIT);
   assign w_is_status = w_in_win && (w_off == OFF_STATUS);
   assign w_cpu_idx   = cpu_addr[IDX_W:1];
   assign w_cpu_is_y  = cpu_addr[0];
   assign w_coord_we  = cpu_wren && w_is_coord;
   assign w_commit_st = cpu_wren && w_is_commit;
   assign ram_wren    = cpu_wren && !w_in_win;
   assign w_unused    = ^cpu_data[31:COORD_W];

   assign w_copying = r_state == StCopy;
   assign w_cp_we_x = w_copying && !r_dirty_x[r_copy_idx];
   assign w_cp_we_y = w_copying && !r_dirty_y[r_copy_idx];

   always_comb begin
      w_set_x = '0;
      w_set_y = '0;
      if (w_coord_we) begin
         if (w_cpu_is_y) w_set_y[w_cpu_idx] = 1'b1;
         else            w_set_x[w_cpu_idx] = 1'b1;
      end
   end

   always_comb begin
      w_state_d          = r_state;
      w_active_bank_d    = r_active_bank;
      w_commit_latched_d = r_commit_latched;
      w_copy_idx_d       = r_copy_idx;
      w_swap             = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_commit_st) w_state_d = StPending;
         end
         StPending: begin
            if (vga_frame_start) begin
               w_active_bank_d = ~r_active_bank;
               w_swap          = 1'b1;
               w_copy_idx_d    = '0;
               w_state_d       = StCopy;
            end
         end
         StCopy: begin
            w_copy_idx_d = r_copy_idx + 1'b1;
            if (w_commit_st) w_commit_latched_d = 1'b1;
            if (r_copy_idx == IDX_W'(N_BOIDS - 1)) begin
               w_state_d          = (r_commit_latched || w_commit_st) ? StPending : StIdle;
               w_commit_latched_d = 1'b0;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_state          <= StIdle;
         r_active_bank    <= 1'b0;
         r_commit_latched <= 1'b0;
         r_copy_idx       <= '0;
         r_dirty_x        <= '0;
         r_dirty_y        <= '0;
         r_frame_count    <= '0;
      end else begin
         r_state          <= w_state_d;
         r_active_bank    <= w_active_bank_d;
         r_commit_latched <= w_commit_latched_d;
         r_copy_idx       <= w_copy_idx_d;
         r_dirty_x        <= w_swap ? '0 : (r_dirty_x | w_set_x);
         r_dirty_y        <= w_swap ? '0 : (r_dirty_y | w_set_y);
         if (vga_frame_start) r_frame_count <= r_frame_count + 1'b1;
      end
   end

   always_comb begin
      w_status                          = '0;
      w_status[STAT_PENDING_BIT]        = r_state == StPending;
      w_status[STAT_BANK_BIT]           = r_active_bank;
      w_status[STAT_COPY_BIT]           = w_copying;
      w_status[STAT_FC_LSB +: FC_W]     = r_frame_count;
      w_mmio_d = '0;
      if (w_is_coord)       w_mmio_d = 32'(w_rb_data);
      else if (w_is_status) w_mmio_d = w_status;
   end

   always_ff @(posedge clock or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_sel_ram <= 1'b0;
         r_mmio_q  <= '0;
         r_rd_x    <= '0;
         r_rd_y    <= '0;
      end else begin
         r_sel_ram <= !w_in_win;
         r_mmio_q  <= w_mmio_d;
         r_rd_x    <= w_disp_x;
         r_rd_y    <= w_disp_y;
      end
   end

   assign cpu_q       = r_sel_ram ? ram_q : r_mmio_q;
   assign vga_rd_x    = r_rd_x;
   assign vga_rd_y    = r_rd_y;
   assign active_bank = r_active_bank;
   assign busy        = r_state != StIdle;

   boid_bank_ram #(
      .N_BOIDS (N_BOIDS),
      .COORD_W (COORD_W)
   ) u_bank_ram (
      .i_clk       (clock),
      .i_rst_n     (CPU_RESETN),
      .i_cpu_we    (w_coord_we),
      .i_cpu_bank  (~r_active_bank),
      .i_cpu_idx   (w_cpu_idx),
      .i_cpu_is_y  (w_cpu_is_y),
      .i_cpu_data  (cpu_data[COORD_W-1:0]),
      .i_cp_we_x   (w_cp_we_x),
      .i_cp_we_y   (w_cp_we_y),
      .i_cp_bank   (~r_active_bank),
      .i_cp_idx    (r_copy_idx),
      .i_cp_x      (w_src_x),
      .i_cp_y      (w_src_y),
      .i_disp_bank (r_active_bank),
      .i_disp_idx  (vga_rd_idx),
      .o_disp_x    (w_disp_x),
      .o_disp_y    (w_disp_y),
      .i_src_bank  (r_active_bank),
      .i_src_idx   (r_copy_idx),
      .o_src_x     (w_src_x),
      .o_src_y     (w_src_y),
      .i_rb_bank   (~r_active_bank),
      .i_rb_idx    (w_cpu_idx),
      .i_rb_is_y   (w_cpu_is_y),
      .o_rb_data   (w_rb_data)
   );

endmodule
